hist_bank_ctrl: RTL and testbench
=================================

Name: hist_bank_ctrl

Overview:
Ping-pong controller for the spectrum bin memory that feeds the histogram display.
- Owns two external single-port BRAM banks, A and B.
- Steers the FFT magnitude stream into the back bank and serves the display's bin reads from the front bank.
- Swaps banks only on a vsync rising edge, so a displayed frame never mixes two spectra.

Parameters:
NBINS, 1024, bins per spectrum frame; a power of two
AW, 10, bin address width; log2(NBINS)
DW, 16, magnitude width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vsync  in  1  display vertical sync, active-high level
hold  in  1  1 = freeze display; swaps are inhibited
fft_valid  in  1  magnitude beat valid
fft_ready  out  1  controller accepts the beat
fft_index  in  AW  bin number of the beat
fft_mag  in  DW  bin magnitude
fft_last  in  1  final beat of the spectrum frame
vaddr  in  AW  display bin address
vdata  out  DW  front-bank data for vaddr, 1-cycle latency
a_addr, b_addr  out  AW  bank addresses
a_we, b_we  out  1  bank write enables
wdata  out  DW  write data, shared by both banks
a_dout, b_dout  in  DW  bank read data, 1-cycle BRAM latency
front  out  1  0 = A is front, 1 = B is front
frame_cnt  out  8  count of completed swaps, wraps at 255 -> 0
short_frame  out  1  sticky: a frame ended with beat count != NBINS

Behaviour:
- States:
  - IDLE: entered from reset; moves to FILL on the first clock after rst_n deasserts.
  - FILL: accepts beats into the back bank.
  - WAIT_SWAP: back bank holds a complete frame; waits for a swap opportunity.
- fft_ready = (state == FILL), combinational from the state register.
- Accepted beat = fft_valid & fft_ready.
- Back-bank port, on an accepted beat: addr = fft_index, we = 1, wdata = fft_mag.
- Back-bank port, otherwise: we = 0, addr = fft_index.
- Front-bank port: addr = vaddr, we = 0, always.
- The we and addr outputs are combinational from state, front and the inputs. No write ever targets the front bank.
- vdata = registered copy of front, taken the same cycle as the address, selecting a_dout or b_dout. Total latency from vaddr to vdata is 1 cycle, so a swap never garbles the first read.
- Beat counter, AW+1 bits:
  - increments per accepted beat;
  - on an accepted fft_last, it is compared with NBINS (the count includes the last beat); a mismatch sets short_frame;
  - it then clears to 0 and the state goes to WAIT_SWAP.
- Edge detect: vs_rise = vsync & ~vsync_q, with vsync_q registered.
- WAIT_SWAP with vs_rise and hold = 0:
  - front toggles;
  - frame_cnt increments;
  - state returns to FILL on the next cycle.
- WAIT_SWAP with hold = 1: stay in WAIT_SWAP with fft_ready = 0, which backpressures the FFT.
- vs_rise in the same cycle as an accepted fft_last: no swap; the swap happens at the next vs_rise.
- vs_rise in FILL: ignored.
- fft_index out of order or repeated: written as given; only the count is checked.
- Reset, whether asynchronous or mid-frame, gives:
  - state = IDLE, front = 0, frame_cnt = 0, short_frame = 0, beat counter = 0, vsync_q = 0;
  - vdata = 0, a_we = b_we = 0, fft_ready = 0.
  Any partial back-bank contents are discarded logically; no clearing pass is made.
- short_frame clears only on reset.

Decomposition:
- Shared package hist_pkg holds:
  - NBINS, AW and DW constants;
  - the state encoding: IDLE = 2'd0, FILL = 2'd1, WAIT_SWAP = 2'd2.
- One sub-module is natural: edge_detect, a registered rising-edge detector reused for vsync, with a parameterised reset value of 0.

Test Plan:
1. Reset, then stream 1024 beats (index i, mag i*3) with fft_last on i = 1023 -> each beat writes to bank B (b_we = 1, b_addr = i); a_we stays 0; fft_ready drops the cycle after the last beat; after vsync rises, front = 1 and frame_cnt = 1.
2. After scenario 1, drive vaddr = 5 -> vdata = 15 one cycle later; drive vaddr = 1023 -> vdata = 3069.
3. Set hold = 1 with the frame complete and apply 3 vsync pulses -> front is unchanged, frame_cnt is unchanged, fft_ready = 0. Release hold, apply the next pulse -> swap occurs and frame_cnt increments.
4. Accepted fft_last in the same cycle as the vsync rising edge -> no swap that cycle; the swap occurs on the following vsync edge.
5. Frame of 1000 beats ending with fft_last -> short_frame = 1 and remains 1 after a following correct 1024-beat frame; the swap still occurs.
6. Assert rst_n = 0 mid-fill at beat 500 -> all outputs take their reset values asynchronously; after release, the next full frame writes to bank B and the first swap makes front = 1.

Source files
------------

// File: rtl/hist_bank_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : hist_pkg
// Brief  : Shared constants and FSM encoding for the histogram bank controller.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hist_pkg;
    localparam int NBINS = 1024;
    localparam int AW    = 10;
    localparam int DW    = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/hist_bank_ctrl_edge_detect.sv
//------------------------------------------------------------------------------
// Module : edge_detect
// Brief  : Registered rising-edge detector with a parameterised reset value.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= RST_VAL;
        else        r_q <= i_d;
    end

    assign o_rise = i_d & ~r_q;
endmodule

`default_nettype wire

// File: rtl/hist_bank_ctrl.sv
//------------------------------------------------------------------------------
// Module : hist_bank_ctrl
// Brief  : Ping-pong controller for two spectrum BRAM banks; swaps on vsync.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hist_bank_ctrl
    import hist_pkg::*;
#(
    parameter int NBINS = hist_pkg::NBINS,
    parameter int AW    = hist_pkg::AW,
    parameter int DW    = hist_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vsync,
    input  logic          hold,
    input  logic          fft_valid,
    output logic          fft_ready,
    input  logic [AW-1:0] fft_index,
    input  logic [DW-1:0] fft_mag,
    input  logic          fft_last,
    input  logic [AW-1:0] vaddr,
    output logic [DW-1:0] vdata,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          a_we,
    output logic          b_we,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] a_dout,
    input  logic [DW-1:0] b_dout,
    output logic          front,
    output logic [7:0]    frame_cnt,
    output logic          short_frame
);
    localparam logic [AW:0] C_NBINS = (AW+1)'(NBINS);

    state_t      r_state, w_state_nxt;
    logic        r_front, w_front_nxt;
    logic [7:0]  r_frame_cnt, w_frame_cnt_nxt;
    logic        r_short, w_short_nxt;
    logic [AW:0] r_beat, w_beat_nxt;
    logic [AW:0] w_beat_inc;
    logic        r_rd_sel;
    logic        r_rd_vld;
    logic        w_vs_rise;
    logic        w_accept;

    edge_detect #(.RST_VAL(1'b0)) u_vs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (vsync),
        .o_rise (w_vs_rise)
    );

    assign fft_ready  = (r_state == ST_FILL);
    assign w_accept   = fft_valid & fft_ready;
    assign w_beat_inc = r_beat + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_front     <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_short     <= 1'b0;
            r_beat      <= '0;
            r_rd_sel    <= 1'b0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_front     <= w_front_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_short     <= w_short_nxt;
            r_beat      <= w_beat_nxt;
            r_rd_sel    <= r_front;
            r_rd_vld    <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_front_nxt     = r_front;
        w_frame_cnt_nxt = r_frame_cnt;
        w_short_nxt     = r_short;
        w_beat_nxt      = r_beat;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_FILL;
            ST_FILL: begin
                if (w_accept) begin
                    if (fft_last) begin
                        // The count includes this final beat.
                        if (w_beat_inc != C_NBINS) w_short_nxt = 1'b1;
                        w_beat_nxt  = '0;
                        w_state_nxt = ST_WAIT_SWAP;
                    end else begin
                        w_beat_nxt = w_beat_inc;
                    end
                end
            end
            ST_WAIT_SWAP: begin
                if (w_vs_rise && !hold) begin
                    w_front_nxt     = ~r_front;
                    w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    w_state_nxt     = ST_FILL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Back bank follows the FFT stream, front bank follows the display.
    always_comb begin
        a_we   = 1'b0;
        b_we   = 1'b0;
        a_addr = vaddr;
        b_addr = vaddr;
        if (r_front) begin
            a_addr = fft_index;
            a_we   = w_accept;
        end else begin
            b_addr = fft_index;
            b_we   = w_accept;
        end
    end

    assign wdata       = fft_mag;
    assign vdata       = r_rd_vld ? (r_rd_sel ? b_dout : a_dout) : '0;
    assign front       = r_front;
    assign frame_cnt   = r_frame_cnt;
    assign short_frame = r_short;
endmodule

`default_nettype wire

// File: tb/tb_hist_bank_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_hist_bank_ctrl
// Brief  : Randomised self-checking bench for hist_bank_ctrl with a frame model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hist_bank_ctrl;
    localparam int NBINS = 1024;
    localparam int AW    = 10;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vsync, hold, fft_valid, fft_last;
    logic          fft_ready;
    logic [AW-1:0] fft_index, vaddr;
    logic [DW-1:0] fft_mag, vdata, wdata, a_dout, b_dout;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_we, b_we, front, short_frame;
    logic [7:0]    frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    hist_bank_ctrl dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .hold(hold),
        .fft_valid(fft_valid), .fft_ready(fft_ready), .fft_index(fft_index),
        .fft_mag(fft_mag), .fft_last(fft_last), .vaddr(vaddr), .vdata(vdata),
        .a_addr(a_addr), .b_addr(b_addr), .a_we(a_we), .b_we(b_we),
        .wdata(wdata), .a_dout(a_dout), .b_dout(b_dout), .front(front),
        .frame_cnt(frame_cnt), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    // External single-port BRAMs
    logic [DW-1:0] mem_a [NBINS];
    logic [DW-1:0] mem_b [NBINS];
    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= wdata;
        a_dout <= mem_a[a_addr];
    end
    always @(posedge clk) begin
        if (b_we) mem_b[b_addr] <= wdata;
        b_dout <= mem_b[b_addr];
    end

    // Reference model: logical bank contents plus frame bookkeeping
    logic [DW-1:0] m_mem   [2][NBINS];
    bit            m_known [2][NBINS];
    bit            m_started, m_filling, m_front, m_short, m_vs_prev;
    bit            m_vd_known;
    int            m_beats, m_frames;
    logic [DW-1:0] m_vdata;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic m_reset();
        m_started = 0; m_filling = 0; m_front = 0; m_short = 0; m_vs_prev = 0;
        m_beats = 0; m_frames = 0; m_vdata = '0; m_vd_known = 1;
    endtask

    task automatic model_step();
        bit vs_rise;
        if (!rst_n) begin
            m_reset();
        end else begin
            vs_rise   = vsync && !m_vs_prev;
            m_vs_prev = vsync;
            m_vd_known = m_known[m_front][vaddr];
            m_vdata    = m_mem[m_front][vaddr];
            if (!m_started) begin
                m_started = 1;
                m_filling = 1;
            end else if (m_filling) begin
                if (fft_valid) begin
                    m_mem[!m_front][fft_index]   = fft_mag;
                    m_known[!m_front][fft_index] = 1;
                    m_beats++;
                    if (fft_last) begin
                        if (m_beats != NBINS) m_short = 1;
                        m_beats   = 0;
                        m_filling = 0;
                    end
                end
            end else if (vs_rise && !hold) begin
                m_front   = !m_front;
                m_frames  = (m_frames + 1) % 256;
                m_filling = 1;
            end
        end
    endtask

    task automatic comb_checks();
        bit acc;
        acc = fft_valid && m_filling;
        check("ready", fft_ready, m_filling);
        if (m_front) begin
            check("a_we", a_we, acc);  check("b_we", b_we, 0);
            check("a_addr", a_addr, fft_index); check("b_addr", b_addr, vaddr);
        end else begin
            check("b_we", b_we, acc);  check("a_we", a_we, 0);
            check("b_addr", b_addr, fft_index); check("a_addr", a_addr, vaddr);
        end
        if (acc) check("wdata", wdata, fft_mag);
        if (m_vd_known) check("vdata", vdata, m_vdata);
        check("front", front, m_front);
        check("frame_cnt", frame_cnt, m_frames);
        check("short_frame", short_frame, m_short);
    endtask

    task automatic tick();
        @(negedge clk);
        comb_checks();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_vsync();
        vsync = 0; tick();
        vsync = 1; tick(); tick();
        vsync = 0; tick();
    endtask

    // mode 0: index i, mag i*3; mode 1: random index and magnitude
    task automatic send_frame(input int n, input bit gaps, input bit mode,
                              input bit vs_on_last, input bit rand_vs, input int abort_at);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n && cyc < n * 4 + 200) begin
            if (i == abort_at) break;
            fft_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
            fft_index = mode ? AW'($urandom) : AW'(i);
            fft_mag   = mode ? DW'($urandom) : DW'(i * 3);
            fft_last  = (i == n - 1);
            vaddr     = AW'($urandom);
            if (vs_on_last)   vsync = (i == n - 1);
            else if (rand_vs) vsync = ($urandom % 4 == 0);
            acc = fft_valid && m_filling;
            tick();
            if (acc) i++;
            cyc++;
        end
        if (abort_at < 0) check("frame_beats", i, n);
        fft_valid = 0;
        fft_last  = 0;
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < NBINS; k++) m_known[b][k] = 0;
        rst_n = 0; vsync = 0; hold = 0; fft_valid = 0; fft_last = 0;
        fft_index = '0; fft_mag = '0; vaddr = '0;
        m_reset();
        repeat (3) tick();
        rst_n = 1;

        // 1: full ramp frame into B, then swap
        send_frame(NBINS, 0, 0, 0, 0, -1);
        check("ready_after_last", fft_ready, 0);
        pulse_vsync();
        check("t1_front", front, 1);
        check("t1_frames", frame_cnt, 1);

        // 2: display reads from the new front bank
        vaddr = 5;    tick(); check("t2_vdata5", vdata, 15);
        vaddr = 1023; tick(); check("t2_vdata1023", vdata, 3069);

        // 3: hold inhibits swaps
        send_frame(NBINS, 1, 1, 0, 0, -1);
        hold = 1;
        repeat (3) pulse_vsync();
        check("t3_front_held", front, 1);
        check("t3_frames_held", frame_cnt, 1);
        check("t3_ready_held", fft_ready, 0);
        hold = 0;
        pulse_vsync();
        check("t3_front", front, 0);
        check("t3_frames", frame_cnt, 2);

        // 4: vsync rise coincident with the last beat does not swap
        send_frame(NBINS, 0, 1, 1, 0, -1);
        tick();
        check("t4_front_noswap", front, 0);
        check("t4_frames_noswap", frame_cnt, 2);
        pulse_vsync();
        check("t4_front", front, 1);
        check("t4_frames", frame_cnt, 3);

        // 5: short frame is sticky
        send_frame(1000, 1, 1, 0, 0, -1);
        pulse_vsync();
        check("t5_short", short_frame, 1);
        check("t5_frames", frame_cnt, 4);
        send_frame(NBINS, 1, 1, 0, 0, -1);
        pulse_vsync();
        check("t5_short_sticky", short_frame, 1);
        check("t5_front", front, 1);
        check("t5_frames2", frame_cnt, 5);

        // 6: asynchronous reset mid-fill
        pulse_vsync();
        send_frame(NBINS, 0, 1, 0, 0, 500);
        #2 rst_n = 0;
        m_reset();
        #1;
        check("t6_ready", fft_ready, 0);
        check("t6_a_we", a_we, 0);
        check("t6_b_we", b_we, 0);
        check("t6_vdata", vdata, 0);
        check("t6_front", front, 0);
        check("t6_frames", frame_cnt, 0);
        check("t6_short", short_frame, 0);
        repeat (2) tick();
        rst_n = 1;
        send_frame(NBINS, 1, 1, 0, 0, -1);
        pulse_vsync();
        check("t6_front_after", front, 1);
        check("t6_frames_after", frame_cnt, 1);

        // Random frames, lengths, vsync noise and hold
        for (int f = 0; f < 6; f++) begin
            int n;
            n = ($urandom % 4 == 0) ? int'($urandom_range(900, 1100)) : NBINS;
            send_frame(n, 1, 1, 0, 1, -1);
            for (int t = 0; t < 6 && !m_filling; t++) begin
                hold = (t < 2) ? 1'($urandom % 2) : 1'b0;
                pulse_vsync();
            end
            hold = 0;
            check("rand_drain_ready", fft_ready, 1);
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
